// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem reads and
// presents a registered instruction to decode, with a one-entry skid, redirect and HALT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        stall,
    input  logic        halt,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        halted
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] SKID   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc;
    logic        squash;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc;

    logic        consume;
    logic        out_free;
    logic        fetch_done;
    logic        take_redirect;
    logic        take_halt;
    logic        skid_load;
    logic [15:0] addr_next;

    assign consume       = instr_valid & ~stall;
    assign out_free      = ~instr_valid | ~stall;
    assign fetch_done    = imem_req & imem_done;
    assign take_redirect = redirect & (state != HALTED);
    assign take_halt     = halt & consume & ~redirect & (state != HALTED);
    assign addr_next     = imem_addr + 16'd2;

    // A returned word that cannot enter the output register goes to the skid.
    assign skid_load = (state == FETCH) & ~take_redirect & ~take_halt &
                       fetch_done & ~squash & ~out_free;

    // NOTE: non-blocking assignments throughout; a later assignment in the
    // same branch overrides an earlier default (e.g. load after consume).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= 16'h0000;
            pc_plus2    <= 16'h0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (take_redirect) begin
                        pc          <= redirect_target;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        // The address stays frozen; only the data is dropped.
                        if (fetch_done) begin
                            imem_req <= 1'b0;
                            squash   <= 1'b0;
                        end else if (imem_req) begin
                            squash <= 1'b1;
                        end
                    end else if (take_halt) begin
                        state       <= HALTED;
                        halted      <= 1'b1;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        if (fetch_done) begin
                            imem_req <= 1'b0;
                            squash   <= 1'b0;
                        end
                    end else begin
                        if (consume) begin
                            instr_valid <= 1'b0;
                            instr       <= NOP_INSTR;
                        end
                        if (fetch_done) begin
                            if (squash) begin
                                squash   <= 1'b0;
                                imem_req <= 1'b0;
                            end else if (out_free) begin
                                instr       <= imem_rdata;
                                instr_pc    <= imem_addr;
                                pc_plus2    <= addr_next;
                                instr_valid <= 1'b1;
                                pc          <= addr_next;
                                // Keep imem_req high: back-to-back fetch of the next word.
                                imem_addr   <= addr_next;
                            end else begin
                                pc       <= addr_next;
                                imem_req <= 1'b0;
                                state    <= SKID;
                            end
                        end else if (!imem_req && out_free) begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end
                end

                SKID: begin
                    if (take_redirect) begin
                        pc          <= redirect_target;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        state       <= FETCH;
                    end else if (take_halt) begin
                        state       <= HALTED;
                        halted      <= 1'b1;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                    end else if (consume) begin
                        instr    <= skid_instr;
                        instr_pc <= skid_pc;
                        pc_plus2 <= skid_pc + 16'd2;
                        state    <= FETCH;
                    end
                end

                HALTED: begin
                    if (fetch_done) begin
                        imem_req <= 1'b0;
                        squash   <= 1'b0;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

    // NOTE: the skid data is deliberately not reset; it is only read in SKID,
    // which can only be entered through skid_load.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_instr <= imem_rdata;
            skid_pc    <= imem_addr;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage for the WISC-SP13 datapath. It holds the PC and issues one-outstanding-request reads to a stalling instruction memory. It presents a registered 16-bit instruction to the decode stage, whose control unit slices opcode = instr[15:11] and func = instr[1:0]. It also absorbs decode stalls with a one-entry skid register, applies taken branch/jump redirects, and stops on HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, value driven on instr when instr_valid=0.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
imem_req  output  1  read request; held high with imem_addr stable until imem_done.
imem_addr  output  16  word-aligned fetch address.
imem_rdata  input  16  read data; valid only in a cycle with imem_done=1.
imem_done  input  1  read complete; may assert in the same cycle imem_req first rises.
stall  input  1  decode cannot accept; output register holds while instr_valid=1.
halt  input  1  decode saw HALT in the current output instruction.
redirect  input  1  taken branch/jump from execute.
redirect_target  input  16  new PC on redirect.
instr  output  16  instruction to decode.
instr_pc  output  16  address of instr.
pc_plus2  output  16  instr_pc+2, mod 2^16.
instr_valid  output  1  instr is a live instruction.
halted  output  1  fetch permanently stopped until reset.

Behaviour:
- Reset (rst_n=0, immediate, no clock needed):
  - pc=RESET_PC; state=FETCH; imem_req=0; imem_addr=RESET_PC.
  - instr=NOP_INSTR; instr_pc=0; pc_plus2=0; instr_valid=0; halted=0; skid empty; squash=0.
- States: FETCH, SKID, HALTED.
- Consume: decode consumes the output in any cycle with instr_valid=1 and stall=0.
- FETCH, idle: raise imem_req with imem_addr=pc when (instr_valid=0 or stall=0) and no redirect/halt that cycle. imem_req is registered, so it is first high the cycle after reset release.
- FETCH, request outstanding:
  - imem_req stays high and imem_addr stays frozen until imem_done, regardless of stall.
  - Redirect changes pc, never imem_addr, while a request is outstanding.
- imem_done with squash=0:
  - If the output register is free or consumed this cycle: load instr=imem_rdata, instr_pc=imem_addr, pc_plus2=imem_addr+2, instr_valid=1; pc<=imem_addr+2.
  - Else: write the word into skid, go to SKID, drop imem_req.
- imem_done with squash=1: discard data, clear squash, stay in FETCH.
- Throughput: one instruction per cycle when memory returns done in the request cycle and stall=0. Output latency is one cycle after imem_done.
- SKID:
  - No requests.
  - When stall=0, output is consumed, skid moves to output the same edge, return to FETCH.
  - Order must be preserved: no drop, no duplicate.
- Redirect (highest priority, overrides stall and halt):
  - pc<=redirect_target; instr_valid<=0, instr<=NOP_INSTR; skid emptied; state=FETCH.
  - If a request is outstanding and imem_done=0, set squash.
  - If imem_done=1 the same cycle, discard that data.
  - Next request uses redirect_target.
- Halt: acted on only when halt=1, instr_valid=1, stall=0, redirect=0.
  - Go to HALTED; halted<=1; instr_valid<=0 and skid emptied.
  - An outstanding request is held to completion, then dropped.
  - HALTED is left only by reset; redirect is ignored in HALTED.
- PC arithmetic is 16-bit unsigned, wrapping 16'hFFFE+2 = 16'h0000. Bit 0 of redirect_target is passed through unchanged; alignment is not checked here.
- stall while instr_valid=0 has no effect.

Test Plan:
1. Single-cycle memory returning A,B,C at 0,2,4 (imem_done same cycle as req), stall=0 -> instr=A,B,C on consecutive cycles, instr_pc=0,2,4, pc_plus2=2,4,6, instr_valid continuous.
2. B on output with stall=1 for 3 cycles; memory returns C 2 cycles after req -> C goes to SKID, imem_req=0 while SKID, B held, C presented the cycle after stall falls, then req for 6.
3. Request to 16'h0006 outstanding, redirect=1 target 16'h0040, done 2 cycles later with 16'h1234 -> instr_valid=0 next cycle, 16'h1234 never appears, next imem_addr=16'h0040.
4. instr=16'h0000 valid with halt=1, stall=0 -> halted=1 next edge, imem_req stays 0, instr_valid=0 for 20 cycles. Repeat with redirect=1 the same cycle -> halted stays 0, fetch resumes at the target.
5. redirect_target=16'hFFFE, word returned -> pc_plus2=16'h0000, following imem_addr=16'h0000.
6. rst_n low mid-request (imem_req=1, instr_valid=1) -> imem_req=0 and instr_valid=0 before the next clock edge. After release, first imem_addr=RESET_PC.
